// File: rtl/coef_sram_pp.sv
// Double-buffered, multi-bank coefficient SRAM for the FIR datapath.
// NBANK read ports use the active plane while one write port fills the shadow plane.
module coef_sram_pp #(
  parameter int NBANK = 8,
  parameter int AW    = 8,
  parameter int DW    = 20,
  parameter int BSW   = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CEN,
  input  logic                  WEN,
  input  logic [BSW+AW-1:0]     CADDR,
  input  logic [DW-1:0]         D,
  input  logic [NBANK*AW-1:0]   A,
  output logic [NBANK*DW-1:0]   Q,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  active_sel,
  output logic [BSW+AW:0]       wr_cnt
);

  localparam int CW    = BSW + AW + 1;
  localparam int DEPTH = 1 << AW;

  localparam logic [CW-1:0]  WR_FULL = CW'(NBANK * DEPTH);
  localparam logic [BSW:0]   NBANK_W = (BSW + 1)'(NBANK);

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  state_t state;

  logic [DW-1:0] mem [2][NBANK][DEPTH];

  logic [BSW-1:0] wr_bank;
  logic [AW-1:0]  wr_word;
  logic           wr_accept;
  logic           swap_req_q;
  logic           rise;
  logic           do_swap;

  assign wr_bank   = CADDR[BSW+AW-1:AW];
  assign wr_word   = CADDR[AW-1:0];
  assign wr_accept = ~CEN & ~WEN & ({1'b0, wr_bank} < NBANK_W);
  assign rise      = swap_req & ~swap_req_q;

  // A swap only lands on an edge without an accepted write, so a burst
  // always finishes in the plane it started in.
  assign do_swap   = ~wr_accept & ((state == PEND) | rise);

  // NOTE: storage arrays get no reset branch; contents survive rst and stay X until written.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[~active_sel][wr_bank][wr_word] <= D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q <= '0;
    end else if (!CEN) begin
      for (int b = 0; b < NBANK; b++) begin
        Q[b*DW +: DW] <= mem[active_sel][b][A[b*AW +: AW]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      swap_req_q <= 1'b0;
      swap_ack   <= 1'b0;
      active_sel <= 1'b0;
      wr_cnt     <= '0;
    end else begin
      swap_req_q <= swap_req;
      swap_ack   <= do_swap;
      if (do_swap) begin
        active_sel <= ~active_sel;
        wr_cnt     <= '0;
        state      <= IDLE;
      end else begin
        if (wr_accept && (wr_cnt != WR_FULL)) begin
          wr_cnt <= wr_cnt + CW'(1);
        end
        if (rise) begin
          state <= PEND;
        end
      end
    end
  end

endmodule

// File: tb/tb_coef_sram_pp.sv
// Randomized self-checking bench for coef_sram_pp against a plane/bank array model.
module tb_coef_sram_pp;

  localparam int NBANK = 8;
  localparam int AW    = 8;
  localparam int DW    = 20;
  localparam int BSW   = 3;
  localparam int CAW   = BSW + AW;
  localparam int CW    = BSW + AW + 1;
  localparam int DEPTH = 256;
  localparam int FULL  = NBANK * DEPTH;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                CEN = 1'b1;
  logic                WEN = 1'b1;
  logic [CAW-1:0]      CADDR = '0;
  logic [DW-1:0]       D = '0;
  logic [NBANK*AW-1:0] A = '0;
  logic [NBANK*DW-1:0] Q;
  logic                swap_req = 1'b0;
  logic                swap_ack;
  logic                active_sel;
  logic [CW-1:0]       wr_cnt;

  coef_sram_pp #(.NBANK(NBANK), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .CEN(CEN), .WEN(WEN), .CADDR(CADDR), .D(D), .A(A),
    .Q(Q), .swap_req(swap_req), .swap_ack(swap_ack), .active_sel(active_sel),
    .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] ref_mem [2][NBANK][DEPTH];
  bit            ref_wr  [2][NBANK][DEPTH];
  logic [DW-1:0] exp_q   [NBANK];
  bit            exp_known [NBANK];
  int            ref_sel  = 0;
  int            ref_cnt  = 0;
  int            ref_ack  = 0;
  bit            ref_pend = 0;
  bit            ref_prev = 0;

  int n_tests  = 0;
  int n_fail   = 0;
  int ack_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NBANK*AW-1:0] rand_a();
    logic [NBANK*AW-1:0] r;
    for (int b = 0; b < NBANK; b++) r[b*AW +: AW] = AW'($urandom);
    return r;
  endfunction

  task automatic compare_all();
    for (int b = 0; b < NBANK; b++) begin
      if (exp_known[b]) check($sformatf("q%0d", b), 64'(Q[b*DW +: DW]), 64'(exp_q[b]));
    end
    check("active_sel", 64'(active_sel), 64'(ref_sel));
    check("wr_cnt", 64'(wr_cnt), 64'(ref_cnt));
    check("swap_ack", 64'(swap_ack), 64'(ref_ack));
    if (swap_ack) ack_seen++;
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare 1 time unit later.
  task automatic cycle(input logic cen, input logic wen, input logic [CAW-1:0] caddr,
                       input logic [DW-1:0] d, input logic [NBANK*AW-1:0] a, input logic sreq);
    bit rise, acc, pend_now;
    int bk, wd, w;
    @(negedge clk);
    CEN = cen; WEN = wen; CADDR = caddr; D = d; A = a; swap_req = sreq;
    @(posedge clk);
    rise     = sreq && !ref_prev;
    ref_prev = sreq;
    bk  = int'(caddr[CAW-1:AW]);
    wd  = int'(caddr[AW-1:0]);
    acc = !cen && !wen && (bk < NBANK);
    if (!cen) begin
      for (int b = 0; b < NBANK; b++) begin
        w = int'(a[b*AW +: AW]);
        exp_q[b]     = ref_mem[ref_sel][b][w];
        exp_known[b] = ref_wr[ref_sel][b][w];
      end
    end
    if (acc) begin
      ref_mem[1-ref_sel][bk][wd] = d;
      ref_wr[1-ref_sel][bk][wd]  = 1'b1;
    end
    pend_now = ref_pend || rise;
    if (pend_now && !acc) begin
      ref_sel  = 1 - ref_sel;
      ref_cnt  = 0;
      ref_ack  = 1;
      ref_pend = 1'b0;
    end else begin
      ref_ack  = 0;
      ref_pend = pend_now;
      if (acc && ref_cnt < FULL) ref_cnt++;
    end
    #1;
    compare_all();
  endtask

  task automatic write(input logic [CAW-1:0] caddr, input logic [DW-1:0] d, input logic sreq);
    cycle(1'b0, 1'b0, caddr, d, rand_a(), sreq);
  endtask

  task automatic read(input logic [NBANK*AW-1:0] a, input logic sreq);
    cycle(1'b0, 1'b1, '0, '0, a, sreq);
  endtask

  task automatic swap_now();
    cycle(1'b1, 1'b1, '0, '0, '0, 1'b1);
    cycle(1'b1, 1'b1, '0, '0, '0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle and checked before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    CEN = 1'b1; WEN = 1'b1; swap_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int b = 0; b < NBANK; b++) check($sformatf("rst_q%0d", b), 64'(Q[b*DW +: DW]), 64'd0);
    check("rst_active_sel", 64'(active_sel), 64'd0);
    check("rst_swap_ack", 64'(swap_ack), 64'd0);
    check("rst_wr_cnt", 64'(wr_cnt), 64'd0);
    ref_sel = 0; ref_cnt = 0; ref_ack = 0; ref_pend = 1'b0; ref_prev = 1'b0;
    for (int b = 0; b < NBANK; b++) begin
      exp_q[b] = '0;
      exp_known[b] = 1'b1;
    end
    @(posedge clk);
    #1 compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [NBANK*AW-1:0] a;
    logic [DW-1:0] d0, d1, d2, dp;
    logic [CAW-1:0] cen_addr [6];
    int save_cnt, rst_at;

    for (int b = 0; b < NBANK; b++) exp_known[b] = 1'b0;

    do_reset();

    // Full load of plane 1, then saturation
    for (int i = 0; i < FULL; i++) write(CAW'(i), DW'($urandom), 1'b0);
    check("full_cnt", 64'(wr_cnt), 64'(FULL));
    write(CAW'(0), DW'($urandom), 1'b0);
    check("sat_cnt", 64'(wr_cnt), 64'(FULL));
    swap_now();

    // Full load of plane 0 while reading plane 1
    for (int i = 0; i < FULL; i++) cycle(1'b0, 1'b0, CAW'(i), DW'($urandom), rand_a(), 1'b0);
    swap_now();
    for (int i = 0; i < 256; i++) read(rand_a(), 1'b0);

    // Load and swap
    write(11'h305, 20'hABCDE, 1'b0);
    check("ls_cnt", 64'(wr_cnt), 64'd1);
    a = rand_a();
    a[3*AW +: AW] = 8'h05;
    read(a, 1'b0);
    check("ls_old_q3", 64'(Q[3*DW +: DW]), 64'(ref_mem[0][3][5]));
    cycle(1'b1, 1'b1, '0, '0, a, 1'b1);
    check("ls_ack", 64'(swap_ack), 64'd1);
    check("ls_sel", 64'(active_sel), 64'd1);
    check("ls_cnt0", 64'(wr_cnt), 64'd0);
    read(a, 1'b0);
    check("ls_new_q3", 64'(Q[3*DW +: DW]), 64'hABCDE);
    check("ls_ack_drop", 64'(swap_ack), 64'd0);

    // Deferred swap across a 3-write burst
    d0 = DW'($urandom); d1 = DW'($urandom); d2 = DW'($urandom);
    write(11'h000, d0, 1'b0);
    write(11'h101, d1, 1'b1);
    check("def_ack_b1", 64'(swap_ack), 64'd0);
    check("def_sel_b1", 64'(active_sel), 64'd1);
    write(11'h7FF, d2, 1'b1);
    check("def_ack_b2", 64'(swap_ack), 64'd0);
    check("def_cnt3", 64'(wr_cnt), 64'd3);
    cycle(1'b1, 1'b1, '0, '0, '0, 1'b1);
    check("def_ack", 64'(swap_ack), 64'd1);
    check("def_cnt0", 64'(wr_cnt), 64'd0);
    check("def_sel", 64'(active_sel), 64'd0);
    a = rand_a();
    a[0*AW +: AW] = 8'h00;
    a[1*AW +: AW] = 8'h01;
    a[7*AW +: AW] = 8'hFF;
    read(a, 1'b0);
    check("def_q0", 64'(Q[0*DW +: DW]), 64'(d0));
    check("def_q1", 64'(Q[1*DW +: DW]), 64'(d1));
    check("def_q7", 64'(Q[7*DW +: DW]), 64'(d2));

    // Held request gives exactly one swap
    ack_seen = 0;
    for (int i = 0; i < 10; i++) read(rand_a(), 1'b1);
    for (int i = 0; i < 2; i++) read(rand_a(), 1'b0);
    check("held_acks", 64'(ack_seen), 64'd1);

    // Chip disabled: no reads, no writes
    save_cnt = ref_cnt;
    for (int i = 0; i < 6; i++) begin
      cen_addr[i] = CAW'($urandom);
      cycle(1'b1, 1'b0, cen_addr[i], DW'($urandom), rand_a(), 1'b0);
    end
    check("cen_cnt", 64'(wr_cnt), 64'(save_cnt));
    swap_now();
    for (int i = 0; i < 6; i++) begin
      a = rand_a();
      a[int'(cen_addr[i][CAW-1:AW])*AW +: AW] = cen_addr[i][AW-1:0];
      read(a, 1'b0);
    end

    // Random traffic with one reset dropped in mid-burst
    rst_at = $urandom_range(50, 350);
    for (int i = 0; i < 400; i++) begin
      if (i == rst_at) begin
        do_reset();
      end else begin
        cycle(1'b0 ^ ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
              CAW'($urandom), DW'($urandom), rand_a(), ($urandom_range(0, 4) == 0));
      end
    end
    cycle(1'b1, 1'b1, '0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, '0, '0, '0, 1'b0);

    // Reset while a swap is pending
    if (ref_sel == 0) swap_now();
    dp = DW'($urandom);
    write(11'h2A7, dp, 1'b1);
    check("pend_ack", 64'(swap_ack), 64'd0);
    ack_seen = 0;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, '0, '0, '0, 1'b0);
    check("pend_no_ack", 64'(ack_seen), 64'd0);
    check("pend_sel", 64'(active_sel), 64'd0);
    a = rand_a();
    a[2*AW +: AW] = 8'hA7;
    read(a, 1'b0);
    check("pend_q2", 64'(Q[2*DW +: DW]), 64'(dp));
    for (int i = 0; i < 16; i++) read(rand_a(), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/coef_sram_pp.md
# coef_sram_pp

Parametrised, double-buffered multi-bank coefficient SRAM for the FIR datapath. It has NBANK independent read ports, one per tap group, each reading its own bank every cycle. One write port loads a shadow copy of all banks while the filter keeps reading the active copy. A swap handshake exchanges the active and shadow copies at a clean cycle boundary, so the filter switches coefficient sets without a glitch.

## Interface
- NBANK, 8, number of banks, and so of read ports (1..16).
- AW, 8, word-address width per bank; depth is 2^AW.
- DW, 20, coefficient width.
- BSW, $clog2(NBANK) (min 1), derived bank-select width.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- CEN  in  1  chip enable, active-low.
- WEN  in  1  write enable, active-low; valid only when CEN=0.
- CADDR  in  BSW+AW  write address; [BSW+AW-1:AW] selects the bank, [AW-1:0] selects the word.
- D  in  DW  write data.
- A  in  NBANK*AW  flattened read addresses; bank b uses A[b*AW +: AW].
- Q  out  NBANK*DW  registered read data; bank b drives Q[b*DW +: DW].
- swap_req  in  1  swap request; only a rising edge counts.
- swap_ack  out  1  one-cycle pulse, high in the cycle after a swap takes effect.
- active_sel  out  1  index of the copy (plane) the read ports use.
- wr_cnt  out  BSW+AW+1  number of accepted shadow writes since the last swap; saturating.

## Operation
- Storage: 2 planes × NBANK banks × 2^AW words × DW bits. Reads use plane active_sel; writes use plane ~active_sel.
- Memory contents are not reset; they are X until written.
- Write: when CEN=0 and WEN=0 at a posedge, shadow[bank][word] <= D.
  - If bank >= NBANK, the write is ignored and not counted.
- Read: when CEN=0 at a posedge (regardless of WEN), every bank updates Q_b <= active[b][A_b].
  - When CEN=1, Q holds its value and no write occurs.
  - A read and a shadow write in the same cycle never conflict, because they target different planes.
- Swap detection: rise = swap_req & ~swap_req_q, where swap_req_q is a registered copy of swap_req. Holding swap_req high gives exactly one request.
- State machine, two states:
  - IDLE: on rise with no accepted write this cycle: toggle active_sel, clear wr_cnt, set swap_ack, stay in IDLE.
  - IDLE: on rise with an accepted write this cycle: go to PEND; the write lands in the current shadow.
  - PEND: on the first cycle with no accepted write: toggle active_sel, clear wr_cnt, set swap_ack, go to IDLE.
  - PEND: further rises are ignored (the request is already pending).
- wr_cnt: +1 per accepted write; saturates at NBANK*2^AW.
- Reset values: Q=0, swap_ack=0, active_sel=0, wr_cnt=0, swap_req_q=0, state=IDLE.
- Reset mid-operation:
  - An asserted rst clears any pending swap immediately; no swap_ack follows.
  - active_sel returns to 0.
  - Memory contents are retained.

## Timing
- Read latency is 1 cycle: A sampled at posedge k appears on Q after posedge k.
- Write effect: data written at edge k is visible to a read only after a swap.
- Earliest path: swap at edge k+1, read sampled at edge k+2, data on Q after k+2.
- At the swap edge:
  - The read at that same edge still uses the old active_sel.
  - Reads from the next edge onward use the new plane.
- Swap latency from rise: 0 extra edges if no write that cycle; otherwise the first write-free edge.
- Write bursts therefore delay the swap for their full length.
- swap_ack is high for exactly the one cycle following the swap edge.
- active_sel and wr_cnt update at the same edge as the swap.

## Test plan
- Reset: drive rst=1 at random mid-burst -> Q=0, active_sel=0, swap_ack=0, wr_cnt=0; check immediately, without waiting for a clock edge.
- Load and swap:
  - Write plane 1 with CADDR=0x305, D=0xABCDE -> wr_cnt=1, and a read of A3=0x05 still returns the plane-0 value.
  - Pulse swap_req -> swap_ack for one cycle, active_sel=1, wr_cnt=0.
  - Next read of A3=0x05 -> Q3=0xABCDE.
- Deferred swap: rise on swap_req during a 3-write burst (0x000, 0x101, 0x7FF) -> no swap during the burst, and all 3 writes go to the old shadow (wr_cnt=3). Then swap_ack on the first idle cycle, wr_cnt=0; reading those addresses returns the written data.
- Held request and chip disable:
  - swap_req held high for 10 cycles -> exactly one swap_ack.
  - CEN=1 with changing A and D -> Q unchanged, wr_cnt unchanged, no memory change.
- Full load:
  - 2048 random writes to the shadow (NBANK=8, AW=8) -> wr_cnt=2048.
  - One more write -> wr_cnt stays at 2048.
  - After a swap, 256 random 8-port reads match the reference model.
- Reset during PEND: assert rst while a swap is pending -> no swap_ack, active_sel=0, and previously written plane contents are intact.
